bcd_time_scheduler: RTL and testbench

Sequencer that shares one registered `bcd_converter` instance among the three time fields: seconds, minutes and hours. It sits between the clock counters and the 7-segment display driver. On each `start` it snapshots the three binary values and feeds them to the converter one at a time. It captures each BCD result and then publishes all three BCD bytes in the same cycle, so the display never shows a mix of old and new fields.

---
 rtl/bcd_time_scheduler_if.sv | 24 ++
 rtl/bcd_time_scheduler.sv | 134 +++++++++++++
 tb/tb_bcd_time_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_time_scheduler_if.sv
// Request/result bundle between the clock counters, the BCD time scheduler
// and the display driver.
interface bcd_time_scheduler_if;
    logic       start;
    logic [6:0] sec_in;
    logic [6:0] min_in;
    logic [6:0] hr_in;
    logic       busy;
    logic       done;
    logic [7:0] bcd_sec;
    logic [7:0] bcd_min;
    logic [7:0] bcd_hr;
    logic       err;

    modport master (
        output start, sec_in, min_in, hr_in,
        input  busy, done, bcd_sec, bcd_min, bcd_hr, err
    );

    modport slave (
        input  start, sec_in, min_in, hr_in,
        output busy, done, bcd_sec, bcd_min, bcd_hr, err
    );
endinterface

// File: rtl/bcd_time_scheduler.sv
// Shares one registered binary-to-BCD converter among seconds, minutes and hours,
// publishing all three BCD bytes together. Optional clamp/err: BCD_RANGE_CHECK_EN.
module bcd_time_scheduler #(
    parameter int CONV_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_time_scheduler_if.slave    bus,
    output logic [6:0]             conv_data,
    input  logic [7:0]             conv_bcd
);
    localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t             state_reg;
    logic [1:0]         chan_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [6:0]         conv_data_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [7:0]         bcd_sec_reg;
    logic [7:0]         bcd_min_reg;
    logic [7:0]         bcd_hr_reg;
    logic [6:0]         snap_reg   [0:2];
    logic [7:0]         shadow_reg [0:2];

    logic [6:0]         field_in   [0:2];
    logic [6:0]         snap_next  [0:2];
    logic               accept;
    logic               publish;

    assign field_in[0] = bus.sec_in;
    assign field_in[1] = bus.min_in;
    assign field_in[2] = bus.hr_in;

    assign accept  = (state_reg == IDLE) && bus.start;
    assign publish = (state_reg == CAPTURE) && (chan_reg == 2'd2);

`ifdef BCD_RANGE_CHECK_EN
    logic [2:0] clamp_next;
    logic [2:0] clamp_reg;
    logic       err_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_snap
`ifdef BCD_RANGE_CHECK_EN
            assign clamp_next[gi] = (field_in[gi] > 7'd99);
            assign snap_next[gi]  = clamp_next[gi] ? 7'd99 : field_in[gi];
`else
            assign snap_next[gi]  = field_in[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            chan_reg      <= 2'd0;
            wait_cnt_reg  <= '0;
            conv_data_reg <= 7'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            bcd_sec_reg   <= 8'h00;
            bcd_min_reg   <= 8'h00;
            bcd_hr_reg    <= 8'h00;
            for (int i = 0; i < 3; i++) begin
                snap_reg[i]   <= 7'd0;
                shadow_reg[i] <= 8'h00;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 3; i++) snap_reg[i] <= snap_next[i];
                        chan_reg  <= 2'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    conv_data_reg <= snap_reg[chan_reg];
                    wait_cnt_reg  <= '0;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_reg == CNT_W'(CONV_LAT - 1)) state_reg <= CAPTURE;
                    else wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
                CAPTURE: begin
                    shadow_reg[chan_reg] <= conv_bcd;
                    if (chan_reg == 2'd2) begin
                        // Hours come straight from the converter so all three publish together.
                        bcd_sec_reg <= shadow_reg[0];
                        bcd_min_reg <= shadow_reg[1];
                        bcd_hr_reg  <= conv_bcd;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        chan_reg  <= chan_reg + 2'd1;
                        state_reg <= ISSUE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef BCD_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clamp_reg <= 3'b000;
            err_reg   <= 1'b0;
        end else begin
            if (accept)  clamp_reg <= clamp_next;
            if (publish) err_reg   <= |clamp_reg;
        end
    end
    assign bus.err = err_reg;
`else
    assign bus.err = 1'b0;
`endif

    assign conv_data   = conv_data_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.bcd_sec = bcd_sec_reg;
    assign bus.bcd_min = bcd_min_reg;
    assign bus.bcd_hr  = bcd_hr_reg;
endmodule

// File: tb/tb_bcd_time_scheduler.sv
// Self-checking bench for bcd_time_scheduler: directed scenarios plus randomized
// conversions against a decimal-arithmetic reference model.
module tb_bcd_time_scheduler;
`ifdef BCD_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_time_scheduler_if ifa();
    bcd_time_scheduler_if ifb();

    logic [6:0] conv_data_a, conv_data_b;
    logic [7:0] conv_bcd_a, conv_bcd_b, pipe_b0;

    bcd_time_scheduler #(.CONV_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .conv_data(conv_data_a), .conv_bcd(conv_bcd_a)
    );

    bcd_time_scheduler #(.CONV_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave),
        .conv_data(conv_data_b), .conv_bcd(conv_bcd_b)
    );

    // Registered converter models: one stage for dut_a, two for dut_b.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] t;
        logic [6:0] u;
        t = v / 7'd10;
        u = v % 7'd10;
        return {t[3:0], u[3:0]};
    endfunction

    always @(posedge clk) begin
        conv_bcd_a <= to_bcd(conv_data_a);
        pipe_b0    <= to_bcd(conv_data_b);
        conv_bcd_b <= pipe_b0;
    end

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] ref_bcd(input int v);
        int c;
        c = (RANGE && v > 99) ? 99 : v;
        return 8'(((c / 10) * 16) + (c % 10));
    endfunction

    function automatic logic ref_err(input int s, input int m, input int h);
        return RANGE && (s > 99 || m > 99 || h > 99);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int limit, output int n);
        n = 0;
        while (ifa.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (ifa.done !== 1'b1) n = -1;
    endtask

    task automatic wait_done_b(input int limit, output int n);
        n = 0;
        while (ifb.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (ifb.done !== 1'b1) n = -1;
    endtask

    task automatic launch_a(input int s, input int m, input int h);
        ifa.sec_in = 7'(s);
        ifa.min_in = 7'(m);
        ifa.hr_in  = 7'(h);
        ifa.start  = 1'b1;
        tick();
        ifa.start  = 1'b0;
    endtask

    task automatic test_reset;
        logic [33:0] obs;
        rst = 1'b1;
        repeat (3) tick();
        obs = {ifa.busy, ifa.done, ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr, conv_data_a};
        checks++;
        if (obs !== 34'd0 || ifa.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got %h err=%b, expected all zero", obs, ifa.err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int busy_cnt;
        logic early;
        logic [6:0] cd [3];
        busy_cnt = 0;
        early = 1'b0;
        launch_a(45, 30, 12);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            if (ifa.busy === 1'b1) busy_cnt++;
            if (k == 1) cd[0] = conv_data_a;
            if (k == 4) cd[1] = conv_data_a;
            if (k == 7) cd[2] = conv_data_a;
            if (k < 9 && (ifa.done !== 1'b0 || ifa.bcd_sec !== 8'h00)) early = 1'b1;
        end
        checks++;
        if (ifa.done !== 1'b1 || early) begin
            failures++;
            $display("FAIL basic_done_timing: done=%b early=%b, expected done=1 after edge 9 only", ifa.done, early);
        end
        checks++;
        if (busy_cnt != 9) begin
            failures++;
            $display("FAIL basic_busy_len: got %0d cycles, expected 9", busy_cnt);
        end
        checks++;
        if (cd[0] !== 7'd45 || cd[1] !== 7'd30 || cd[2] !== 7'd12) begin
            failures++;
            $display("FAIL basic_conv_data: got %0d/%0d/%0d, expected 45/30/12", cd[0], cd[1], cd[2]);
        end
        checks++;
        if ({ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr} !== 24'h453012) begin
            failures++;
            $display("FAIL basic_result: got %h/%h/%h, expected 45/30/12", ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr);
        end
        tick();
        checks++;
        if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || conv_data_a !== 7'd12) begin
            failures++;
            $display("FAIL basic_after_done: done=%b busy=%b conv_data=%0d, expected 0/0/12", ifa.done, ifa.busy, conv_data_a);
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        ifa.sec_in = 7'd0; ifa.min_in = 7'd59; ifa.hr_in = 7'd23;
        ifa.start = 1'b1;
        tick();
        wait_done_a(30, n1);
        checks++;
        if (n1 != 9 || {ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr} !== 24'h005923) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d result=%h/%h/%h, expected 9 and 00/59/23", n1, ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr);
        end
        ifa.sec_in = 7'd59;
        tick();
        wait_done_a(30, n2);
        ifa.start = 1'b0;
        checks++;
        if (n2 + 1 != 10) begin
            failures++;
            $display("FAIL b2b_period: got %0d cycles between done pulses, expected 10", n2 + 1);
        end
        checks++;
        if ({ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr} !== 24'h595923) begin
            failures++;
            $display("FAIL b2b_second: got %h/%h/%h, expected 59/59/23", ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr);
        end
        repeat (2) tick();
        checks++;
        if (ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b after start dropped, expected 0", ifa.busy);
        end
    endtask

    task automatic test_ignore_start;
        int done_cnt;
        logic [23:0] res;
        done_cnt = 0;
        res = 24'h0;
        launch_a(11, 22, 3);
        for (int k = 0; k < 25; k++) begin
            if (k > 0) tick();
            ifa.start = 1'b0;
            if (k == 3) begin ifa.start = 1'b1; ifa.sec_in = 7'd50; end
            if (k == 5) begin ifa.start = 1'b1; ifa.sec_in = 7'd51; end
            if (ifa.done === 1'b1) begin
                done_cnt++;
                res = {ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr};
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d, expected 1", done_cnt);
        end
        checks++;
        if (res !== 24'h112203) begin
            failures++;
            $display("FAIL ignore_result: got %h, expected 112203", res);
        end
    endtask

    task automatic test_reset_mid;
        int done_cnt, n;
        logic [33:0] obs;
        done_cnt = 0;
        launch_a(33, 44, 5);
        repeat (4) tick();
        checks++;
        if (conv_data_a !== 7'd44 || ifa.busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_position: conv_data=%0d busy=%b, expected 44/1", conv_data_a, ifa.busy);
        end
        rst = 1'b1;
        #1;
        obs = {ifa.busy, ifa.done, ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr, conv_data_a};
        checks++;
        if (obs !== 34'd0 || ifa.err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear: got %h err=%b, expected all zero", obs, ifa.err);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (ifa.done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_no_done: got %0d done pulses, expected 0", done_cnt);
        end
        launch_a(6, 7, 8);
        wait_done_a(30, n);
        checks++;
        if (n != 9 || {ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr} !== 24'h060708) begin
            failures++;
            $display("FAIL rstmid_recover: lat=%0d result=%h/%h/%h, expected 9 and 06/07/08", n, ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr);
        end
    endtask

    task automatic test_range;
        int n;
        launch_a(100, 5, 7);
        wait_done_a(30, n);
        checks++;
        if (n != 9 || ifa.bcd_sec !== ref_bcd(100) || ifa.err !== ref_err(100, 5, 7)) begin
            failures++;
            $display("FAIL range_clamp: lat=%0d sec=%h err=%b, expected 9 sec=%h err=%b", n, ifa.bcd_sec, ifa.err, ref_bcd(100), ref_err(100, 5, 7));
        end
        tick();
        checks++;
        if (ifa.err !== ref_err(100, 5, 7)) begin
            failures++;
            $display("FAIL range_err_hold: err=%b, expected %b", ifa.err, ref_err(100, 5, 7));
        end
        launch_a(1, 2, 3);
        wait_done_a(30, n);
        checks++;
        if (ifa.err !== 1'b0 || {ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr} !== 24'h010203) begin
            failures++;
            $display("FAIL range_clear: err=%b result=%h/%h/%h, expected 0 and 01/02/03", ifa.err, ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr);
        end
    endtask

    task automatic test_random;
        int s, m, h, n;
        for (int it = 0; it < 16; it++) begin
            s = $urandom_range(0, 127);
            m = $urandom_range(0, 127);
            h = $urandom_range(0, 127);
            repeat ($urandom_range(0, 3)) tick();
            launch_a(s, m, h);
            wait_done_a(30, n);
            checks++;
            if (n != 9 || {ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr} !== {ref_bcd(s), ref_bcd(m), ref_bcd(h)}) begin
                failures++;
                $display("FAIL random_result: in=%0d/%0d/%0d lat=%0d got %h/%h/%h, expected 9 and %h/%h/%h", s, m, h, n, ifa.bcd_sec, ifa.bcd_min, ifa.bcd_hr, ref_bcd(s), ref_bcd(m), ref_bcd(h));
            end
            checks++;
            if (ifa.err !== ref_err(s, m, h)) begin
                failures++;
                $display("FAIL random_err: in=%0d/%0d/%0d err=%b, expected %b", s, m, h, ifa.err, ref_err(s, m, h));
            end
        end
    endtask

    task automatic test_lat2;
        int n;
        ifb.sec_in = 7'd7; ifb.min_in = 7'd8; ifb.hr_in = 7'd9;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        wait_done_b(40, n);
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL lat2_timing: done after edge %0d, expected 12", n);
        end
        checks++;
        if ({ifb.bcd_sec, ifb.bcd_min, ifb.bcd_hr} !== 24'h070809 || ifb.busy !== 1'b0) begin
            failures++;
            $display("FAIL lat2_result: got %h/%h/%h busy=%b, expected 07/08/09 busy=0", ifb.bcd_sec, ifb.bcd_min, ifb.bcd_hr, ifb.busy);
        end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.sec_in = 7'd0; ifa.min_in = 7'd0; ifa.hr_in = 7'd0;
        ifb.start = 1'b0; ifb.sec_in = 7'd0; ifb.min_in = 7'd0; ifb.hr_in = 7'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_range();
        test_random();
        test_lat2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
